// File: rtl/decoder_nto2n_scan_if.sv
// Handshake and decoded-output bundle for decoder_nto2n_scan.
// The master drives en/mode/code requests; the slave (decoder) returns the registered one-hot lines.
interface decoder_nto2n_scan_if #(
  parameter int unsigned N = 4
) ();
  logic              en;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      i;
  logic [(1<<N)-1:0] d;
  logic              d_valid;
  logic [N-1:0]      code;
  logic              scan_wrap;

  modport master (
    output en, mode, in_valid, i,
    input  in_ready, d, d_valid, code, scan_wrap
  );

  modport slave (
    input  en, mode, in_valid, i,
    output in_ready, d, d_valid, code, scan_wrap
  );
endinterface

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N one-hot decoder: DIRECT decodes handshaked codes, SCAN sweeps every line.
// Optional DEC_HOLD_ON_DISABLE_EN: en=0 freezes outputs and scan position instead of clearing them.
module decoder_nto2n_scan #(
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 1,
  parameter int unsigned DW_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  decoder_nto2n_scan_if.slave bus
);
  localparam int unsigned W = 1 << N;
  localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    d_q, d_d;
  logic [N-1:0]    code_q, code_d;
  logic            d_valid_q, d_valid_d;
  logic            scan_wrap_q, scan_wrap_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            transfer;
  logic            dwell_last;
  logic            resume_scan;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      d_q         <= '0;
      code_q      <= '0;
      d_valid_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      code_q      <= code_d;
      d_valid_q   <= d_valid_d;
      scan_wrap_q <= scan_wrap_d;
      dwell_q     <= dwell_d;
    end
  end

`ifdef DEC_HOLD_ON_DISABLE_EN
  // Remembers that the block was frozen mid-scan so re-enabling in SCAN continues the sweep.
  logic scan_hold_q, scan_hold_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_hold_q <= 1'b0;
    end else begin
      scan_hold_q <= scan_hold_d;
    end
  end

  always_comb begin
    scan_hold_d = scan_hold_q;
    if (!bus.en && state_q != StIdle) begin
      scan_hold_d = (state_q == StScan);
    end
  end

  assign resume_scan = scan_hold_q && (state_q == StIdle);
`else
  assign resume_scan = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = StIdle;
    end else if (bus.mode) begin
      state_d = StScan;
    end else begin
      state_d = StDirect;
    end
  end

  assign transfer   = bus.in_valid & bus.in_ready;
  assign dwell_last = (dwell_q == DW_W'(DWELL - 1));

  always_comb begin
    d_d         = d_q;
    code_d      = code_q;
    d_valid_d   = d_valid_q;
    dwell_d     = dwell_q;
    scan_wrap_d = 1'b0;
    if (!bus.en) begin
`ifdef DEC_HOLD_ON_DISABLE_EN
      dwell_d = dwell_q;
`else
      d_d       = '0;
      d_valid_d = 1'b0;
      dwell_d   = '0;
`endif
    end else if (bus.mode) begin
      if (state_q == StScan || resume_scan) begin
        if (dwell_last) begin
          dwell_d     = '0;
          code_d      = code_q + 1'b1;
          d_d         = One << code_d;
          d_valid_d   = 1'b1;
          scan_wrap_d = &code_q;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end else begin
        // Fresh entry into SCAN always starts the sweep at line 0.
        dwell_d   = '0;
        code_d    = '0;
        d_d       = One;
        d_valid_d = 1'b1;
      end
    end else if (transfer) begin
      d_d       = One << bus.i;
      code_d    = bus.i;
      d_valid_d = 1'b1;
    end
  end

  assign bus.in_ready  = (state_q == StDirect) & bus.en & ~bus.mode;
  assign bus.d         = d_q;
  assign bus.code      = code_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule
